// File: rtl/fir_stim_gen_if.sv
// Bus between the FIR stimulus generator and whoever commands it.
//
// Handshake: start is a single-cycle request. It is taken only while the
// generator is idle (busy low); a start raised while busy is high, which
// includes the cycle done is high, is dropped without side effects. On the
// output side x_valid qualifies x_out and sample_idx in every cycle it is
// high. There is no backpressure: the consumer must take one sample per
// clock while x_valid is high.
interface fir_stim_gen_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
);
    logic                     start;
    logic [1:0]               mode;
    logic signed [DATA_W-1:0] amp;
    logic [LEN_W-1:0]         length;
    logic [7:0]               lead_zeros;
    logic signed [DATA_W-1:0] x_out;
    logic                     x_valid;
    logic [LEN_W-1:0]         sample_idx;
    logic                     busy;
    logic                     done;
    logic [1:0]               state_dbg;

    modport master (
        output start, mode, amp, length, lead_zeros,
        input  x_out, x_valid, sample_idx, busy, done, state_dbg
    );

    modport slave (
        input  start, mode, amp, length, lead_zeros,
        output x_out, x_valid, sample_idx, busy, done, state_dbg
    );
endinterface

// File: rtl/fir_stim_gen.sv
// Test-pattern source for the 16-tap FIR sample input. Emits lead zeros,
// a burst (impulse / step / PRBS / square) and a fixed run of tail zeros,
// one sample per clock. Samples are computed from the next state so the
// first sample is visible right after the edge that accepts start.
module fir_stim_gen #(
    parameter int          DATA_W     = 16,
    parameter int          LEN_W      = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          SQ_HALF    = 8,
    parameter int          TAIL_ZEROS = 16
) (
    input logic           clk,
    input logic           rst,
    fir_stim_gen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_TAIL} state_t;

    localparam int SQ_W   = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
    localparam int TAIL_W = (TAIL_ZEROS > 1) ? $clog2(TAIL_ZEROS) : 1;
    localparam logic [SQ_W-1:0]   SQ_LAST   = SQ_W'(SQ_HALF - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_ZEROS - 1);
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;
    localparam logic signed [DATA_W-1:0] AMP_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] AMP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    state_t state_q, state_nxt;

    // Command fields captured on an accepted start
    logic [1:0]               mode_q;
    logic signed [DATA_W-1:0] amp_q;
    logic [LEN_W-1:0]         len_q;
    logic [7:0]               lead_q;

    // Per-phase counters: index of the sample currently on x_out
    logic [7:0]        pre_cnt, pre_nxt;
    logic [LEN_W-1:0]  run_cnt, run_nxt;
    logic [TAIL_W-1:0] tail_cnt, tail_nxt;

    // Pattern state
    logic [15:0]              lfsr_q, lfsr_nxt, lfsr_e;
    logic                     sq_neg_q, sq_neg_nxt, sq_neg_e;
    logic [SQ_W-1:0]          sq_cnt_q, sq_cnt_nxt, sq_cnt_e;
    logic [1:0]               mode_e;
    logic signed [DATA_W-1:0] amp_e, neg_amp;
    logic signed [DATA_W-1:0] x_q, x_nxt;

    logic accept, pre_last, run_last, tail_last;

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign pre_last  = (pre_cnt == lead_q - 8'd1);
    assign run_last  = (run_cnt == len_q - LEN_W'(1));
    assign tail_last = (tail_cnt == TAIL_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    // Next-state decode; empty phases are skipped straight away
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.lead_zeros != 8'd0) state_nxt = S_PRE;
                    else if (bus.length != '0)  state_nxt = S_RUN;
                    else                        state_nxt = S_TAIL;
                end
            end
            S_PRE:   if (pre_last)  state_nxt = (len_q != '0) ? S_RUN : S_TAIL;
            S_RUN:   if (run_last)  state_nxt = S_TAIL;
            S_TAIL:  if (tail_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next sample, counters and pattern state for the state being entered;
    // on an accepting edge the live inputs and seed stand in for the latches
    always_comb begin
        mode_e   = accept ? bus.mode : mode_q;
        amp_e    = accept ? bus.amp  : amp_q;
        lfsr_e   = accept ? LFSR_SEED : lfsr_q;
        sq_neg_e = accept ? 1'b0 : sq_neg_q;
        sq_cnt_e = accept ? '0 : sq_cnt_q;
        neg_amp  = (amp_e == AMP_MIN) ? AMP_MAX : -amp_e;

        pre_nxt  = (state_nxt == S_PRE  && state_q == S_PRE)  ? pre_cnt + 8'd1 : 8'd0;
        run_nxt  = (state_nxt == S_RUN  && state_q == S_RUN)  ? run_cnt + LEN_W'(1) : '0;
        tail_nxt = (state_nxt == S_TAIL && state_q == S_TAIL) ? tail_cnt + TAIL_W'(1) : '0;

        x_nxt      = '0;
        lfsr_nxt   = lfsr_e;
        sq_neg_nxt = sq_neg_e;
        sq_cnt_nxt = sq_cnt_e;
        if (state_nxt == S_RUN) begin
            case (mode_e)
                2'd0: x_nxt = (run_nxt == '0) ? amp_e : '0;
                2'd1: x_nxt = amp_e;
                2'd2: begin
                    x_nxt    = DATA_W'($signed(lfsr_e));
                    lfsr_nxt = {1'b0, lfsr_e[15:1]} ^ (lfsr_e[0] ? LFSR_TAPS : 16'h0000);
                end
                default: begin
                    x_nxt = sq_neg_e ? neg_amp : amp_e;
                    if (sq_cnt_e == SQ_LAST) begin
                        sq_cnt_nxt = '0;
                        sq_neg_nxt = ~sq_neg_e;
                    end else begin
                        sq_cnt_nxt = sq_cnt_e + SQ_W'(1);
                    end
                end
            endcase
        end
    end

    // Datapath registers: command latch, counters, pattern state, sample
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 2'd0;
            amp_q    <= '0;
            len_q    <= '0;
            lead_q   <= 8'd0;
            pre_cnt  <= 8'd0;
            run_cnt  <= '0;
            tail_cnt <= '0;
            lfsr_q   <= LFSR_SEED;
            sq_neg_q <= 1'b0;
            sq_cnt_q <= '0;
            x_q      <= '0;
        end else begin
            if (accept) begin
                mode_q <= bus.mode;
                amp_q  <= bus.amp;
                len_q  <= bus.length;
                lead_q <= bus.lead_zeros;
            end
            pre_cnt  <= pre_nxt;
            run_cnt  <= run_nxt;
            tail_cnt <= tail_nxt;
            lfsr_q   <= lfsr_nxt;
            sq_neg_q <= sq_neg_nxt;
            sq_cnt_q <= sq_cnt_nxt;
            x_q      <= x_nxt;
        end
    end

    // Outputs decode straight from registers
    assign bus.x_out      = x_q;
    assign bus.x_valid    = (state_q != S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.sample_idx = run_cnt;
    assign bus.done       = (state_q == S_TAIL) && tail_last;
    assign bus.state_dbg  = state_q;
endmodule
